// File: rtl/axi_init_pkg.sv
// axi_init_pkg: FSM states, AXI encodings and size helper for the burst initiator
package axi_init_pkg;
   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   function automatic logic [2:0] size_enc(input int bytes);
      return 3'($clog2(bytes));
   endfunction
endpackage

// File: rtl/axi_init_pattern_gen.sv
// axi_init_pattern_gen: beat data = (beat address low word XOR seed) replicated across the bus
module axi_init_pattern_gen #(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 64
) (
   input  logic [ADDR_BITS-1:0] beat_addr,
   input  logic [31:0]          seed,
   output logic [DATA_BITS-1:0] data
);
   assign data = {(DATA_BITS / 32){32'(beat_addr) ^ seed}};
endmodule

// File: rtl/axi4_burst_initiator.sv
// axi4_burst_initiator: write-then-read AXI4 burst generator with readback checking
// Build macro AXI_INIT_ERR_LOG_EN adds first-error address capture ports.
module axi4_burst_initiator
   import axi_init_pkg::*;
#(
   parameter int ADDR_BITS  = 32,
   parameter int DATA_BITS  = 64,
   parameter int ID_BITS    = 5,
   parameter int BURST_LEN  = 8,
   parameter int NUM_BURSTS = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_BITS-1:0]   start_addr,
   input  logic [31:0]            seed,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            err_count,
`ifdef AXI_INIT_ERR_LOG_EN
   output logic [ADDR_BITS-1:0]   first_err_addr,
   output logic                   first_err_valid,
`endif
   output logic                   axi_aw_valid,
   output logic [ADDR_BITS-1:0]   axi_aw_bits_addr,
   output logic [7:0]             axi_aw_bits_len,
   output logic [2:0]             axi_aw_bits_size,
   output logic [1:0]             axi_aw_bits_burst,
   output logic [ID_BITS-1:0]     axi_aw_bits_id,
   output logic                   axi_aw_bits_lock,
   output logic [3:0]             axi_aw_bits_cache,
   output logic [2:0]             axi_aw_bits_prot,
   output logic [3:0]             axi_aw_bits_qos,
   input  logic                   axi_aw_ready,
   output logic                   axi_w_valid,
   output logic [DATA_BITS-1:0]   axi_w_bits_data,
   output logic [DATA_BITS/8-1:0] axi_w_bits_strb,
   output logic                   axi_w_bits_last,
   input  logic                   axi_w_ready,
   input  logic                   axi_b_valid,
   input  logic [1:0]             axi_b_bits_resp,
   input  logic [ID_BITS-1:0]     axi_b_bits_id,
   output logic                   axi_b_ready,
   output logic                   axi_ar_valid,
   output logic [ADDR_BITS-1:0]   axi_ar_bits_addr,
   output logic [7:0]             axi_ar_bits_len,
   output logic [2:0]             axi_ar_bits_size,
   output logic [1:0]             axi_ar_bits_burst,
   output logic [ID_BITS-1:0]     axi_ar_bits_id,
   output logic                   axi_ar_bits_lock,
   output logic [3:0]             axi_ar_bits_cache,
   output logic [2:0]             axi_ar_bits_prot,
   output logic [3:0]             axi_ar_bits_qos,
   input  logic                   axi_ar_ready,
   input  logic                   axi_r_valid,
   input  logic [DATA_BITS-1:0]   axi_r_bits_data,
   input  logic [1:0]             axi_r_bits_resp,
   input  logic                   axi_r_bits_last,
   input  logic [ID_BITS-1:0]     axi_r_bits_id,
   output logic                   axi_r_ready
);
   localparam int WORD = DATA_BITS / 8;
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int NW = $clog2(NUM_BURSTS + 1);
   localparam logic [ADDR_BITS-1:0] BURST_BYTES = ADDR_BITS'(BURST_LEN * WORD);
   localparam logic [ADDR_BITS-1:0] WORD_BYTES = ADDR_BITS'(WORD);
   state_t state, next_state;
   logic [ADDR_BITS-1:0] base, start_r, beat_addr;
   logic [31:0] seed_r;
   logic [BW-1:0] beat;
   logic [NW-1:0] burst;
   logic [DATA_BITS-1:0] exp_data;
   logic last_beat, last_burst, accept, w_hs, b_hs, r_hs, err_ev;
   assign beat_addr = base + ADDR_BITS'(beat) * WORD_BYTES;
   assign last_beat = beat == BW'(BURST_LEN - 1);
   assign last_burst = burst == NW'(NUM_BURSTS - 1);
   assign accept = state == IDLE && start;
   assign w_hs = state == W && axi_w_ready;
   assign b_hs = state == B && axi_b_valid;
   assign r_hs = state == R && axi_r_valid;
   assign err_ev = (b_hs && (axi_b_bits_resp != RESP_OKAY || axi_b_bits_id != '0)) ||
                   (r_hs && (axi_r_bits_data != exp_data || axi_r_bits_resp != RESP_OKAY ||
                             axi_r_bits_id != '0 || axi_r_bits_last != last_beat));
   assign axi_aw_bits_addr = base;
   assign axi_ar_bits_addr = base;
   assign axi_aw_bits_len = 8'(BURST_LEN - 1);
   assign axi_ar_bits_len = 8'(BURST_LEN - 1);
   assign axi_aw_bits_size = size_enc(WORD);
   assign axi_ar_bits_size = size_enc(WORD);
   assign axi_aw_bits_burst = BURST_INCR;
   assign axi_ar_bits_burst = BURST_INCR;
   assign axi_aw_bits_id = '0;
   assign axi_ar_bits_id = '0;
   assign axi_aw_bits_lock = 1'b0;
   assign axi_ar_bits_lock = 1'b0;
   assign axi_aw_bits_cache = '0;
   assign axi_ar_bits_cache = '0;
   assign axi_aw_bits_prot = '0;
   assign axi_ar_bits_prot = '0;
   assign axi_aw_bits_qos = '0;
   assign axi_ar_bits_qos = '0;
   assign axi_w_bits_strb = '1;
   assign axi_w_bits_last = last_beat;
   axi_init_pattern_gen #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_wgen (
      .beat_addr(beat_addr), .seed(seed_r), .data(axi_w_bits_data));
   axi_init_pattern_gen #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_rchk (
      .beat_addr(beat_addr), .seed(seed_r), .data(exp_data));
   // State register; reset drops every valid/ready at once since they decode from state
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= next_state;
   // Next-state and handshake outputs, all decoded from the registered state only
   always_comb begin
      next_state = state;
      axi_aw_valid = state == AW;
      axi_w_valid = state == W;
      axi_b_ready = state == B;
      axi_ar_valid = state == AR;
      axi_r_ready = state == R;
      busy = state != IDLE;
      done = state == DONE;
      case (state)
         IDLE: next_state = start ? AW : IDLE;
         AW: next_state = axi_aw_ready ? W : AW;
         W: next_state = (axi_w_ready && last_beat) ? B : W;
         B: next_state = axi_b_valid ? (last_burst ? AR : AW) : B;
         AR: next_state = axi_ar_ready ? R : AR;
         R: next_state = (axi_r_valid && last_beat) ? (last_burst ? DONE : AR) : R;
         default: next_state = IDLE;
      endcase
   end
   // Burst base, beat and burst counters; base rewinds to the run start for the read phase
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         base <= '0;
         start_r <= '0;
         seed_r <= '0;
         beat <= '0;
         burst <= '0;
      end else if (accept) begin
         base <= start_addr;
         start_r <= start_addr;
         seed_r <= seed;
         beat <= '0;
         burst <= '0;
      end else begin
         if (w_hs || r_hs) beat <= last_beat ? '0 : beat + 1'b1;
         if (b_hs || (r_hs && last_beat)) begin
            burst <= last_burst ? '0 : burst + 1'b1;
            base <= (b_hs && last_burst) ? start_r : base + BURST_BYTES;
         end
      end
   // Saturating error total, cleared when a run is accepted and held afterwards
   always_ff @(posedge clock or negedge reset)
      if (!reset) err_count <= '0;
      else if (accept) err_count <= '0;
      else if (err_ev && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`ifdef AXI_INIT_ERR_LOG_EN
   // Latch the beat address of the first error in a run (burst base for a B error)
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         first_err_valid <= 1'b0;
         first_err_addr <= '0;
      end else if (accept) begin
         first_err_valid <= 1'b0;
         first_err_addr <= '0;
      end else if (err_ev && !first_err_valid) begin
         first_err_valid <= 1'b1;
         first_err_addr <= beat_addr;
      end
`endif
endmodule

// File: doc/axi4_burst_initiator.md
AXI4_BURST_INITIATOR -- requirements
Module: axi4_burst_initiator

Interface
- REQ-001 SHALL have parameter ADDR_BITS, default 32, AXI address width.
- REQ-002 SHALL have parameter DATA_BITS, default 64, AXI data width (multiple of 32).
- REQ-003 SHALL have parameter ID_BITS, default 5, AXI ID width.
- REQ-004 SHALL have parameter BURST_LEN, default 8, beats per burst (1..256).
- REQ-005 SHALL have parameter NUM_BURSTS, default 4, bursts per test run (>=1).
- REQ-006 SHALL have port clock, input, 1, sole clock; all logic rising-edge.
- REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
- REQ-008 SHALL have port start, input, 1, one-cycle pulse that launches a run.
- REQ-009 SHALL have ports start_addr (input, ADDR_BITS, run base address, WORD_SIZE-aligned) and seed (input, 32, pattern seed); both sampled on accepted start.
- REQ-010 SHALL have ports busy (output, 1, run in progress), done (output, 1, one-cycle run-complete pulse) and err_count (output, 16, saturating error total of last run).
- REQ-011 SHALL have AW outputs axi_aw_valid, axi_aw_bits_addr [ADDR_BITS], axi_aw_bits_len [8], axi_aw_bits_size [3], axi_aw_bits_burst [2] and axi_aw_bits_id [ID_BITS], plus input axi_aw_ready.
- REQ-012 SHALL have W outputs axi_w_valid, axi_w_bits_data [DATA_BITS], axi_w_bits_strb [DATA_BITS/8] and axi_w_bits_last, plus input axi_w_ready.
- REQ-013 SHALL have B inputs axi_b_valid, axi_b_bits_resp [2] and axi_b_bits_id [ID_BITS], plus output axi_b_ready.
- REQ-014 SHALL have AR ports mirroring REQ-011 with the axi_ar_ prefix.
- REQ-015 SHALL have R inputs axi_r_valid, axi_r_bits_data, axi_r_bits_resp, axi_r_bits_last and axi_r_bits_id, plus output axi_r_ready.
- REQ-016 SHALL drive outputs lock/cache/prot/qos on both AW and AR as constant 0.

Function
- REQ-017 SHALL implement FSM states IDLE, AW, W, B, AR, R, DONE; at most one transaction outstanding.
- REQ-018 SHALL transition IDLE->AW on start; start while busy SHALL be ignored.
- REQ-019 SHALL run the write phase first: per burst AW->W->B, repeated NUM_BURSTS times; then the read phase: per burst AR->R, repeated NUM_BURSTS times; then DONE->IDLE after one cycle.
- REQ-020 SHALL compute burst n base address as start_addr + n*BURST_LEN*(DATA_BITS/8), wrapping modulo 2^ADDR_BITS.
- REQ-021 SHALL drive len=BURST_LEN-1, size=log2(DATA_BITS/8), burst=INCR (01), id=0, strb all ones.
- REQ-022 SHALL form beat data as the 32-bit word (beat_addr[31:0] XOR seed) replicated DATA_BITS/32 times.
- REQ-023 SHALL hold each valid high, with its payload stable, until the matching ready is sampled high; valid SHALL NOT depend combinationally on ready.
- REQ-024 SHALL assert w_last only on beat BURST_LEN-1 and SHALL permit W valid only after the AW handshake.
- REQ-025 SHALL assert b_ready only in state B and r_ready only in state R.
- REQ-026 SHALL count one error for each of: B resp != OKAY, B id != 0, R data mismatch, R resp != OKAY, R id != 0, r_last disagreeing with beat index; multiple errors on one beat SHALL count once.
- REQ-027 SHALL saturate err_count at 16'hFFFF, clear it on accepted start, and hold it after done.
- REQ-028 SHALL keep busy high from the cycle after start through the DONE cycle.

Reset
- REQ-029 SHALL on reset low force IDLE, all valids/readys low, busy=0, done=0, err_count=0, immediately, including mid-burst.
- REQ-030 SHALL clear address/beat/burst counters on reset; after reset release, SHALL issue no AXI traffic until start.

Configuration
- REQ-031 SHALL, with AXI_INIT_ERR_LOG_EN defined, add outputs first_err_addr [ADDR_BITS] and first_err_valid [1] capturing the beat address of the first error in a run (cleared on start).
- REQ-032 SHALL, without AXI_INIT_ERR_LOG_EN, omit those ports and logic; all other behaviour is identical.

Structure
- REQ-033 SHALL place the state enum, the AXI burst/resp encodings (INCR, OKAY) and the size-encoding function in package axi_init_pkg.
- REQ-034 SHALL implement the pattern of REQ-022 in sub-module axi_init_pattern_gen (inputs beat_addr, seed; output data), instantiated for both write generation and read checking.

Verification
- REQ-035 Bench SHALL cover: start_addr=0x1000, seed=0xA5A5A5A5, zero-latency responder -> 32 W beats, data beat0=0xA5A5B5A5A5A5B5A5, done pulse, err_count=0.
- REQ-036 Bench SHALL cover: random ready stalls 0-7 cycles on all channels -> payload stable while stalled, err_count=0.
- REQ-037 Bench SHALL cover: responder corrupts read beat 5 of burst 2, then returns SLVERR on one B -> err_count=2; first_err_addr=0x1000 (when AXI_INIT_ERR_LOG_EN is defined).
- REQ-038 Bench SHALL cover: start_addr=0xFFFFFFC0 -> addresses wrap to 0x00000000 on burst 1.
- REQ-039 Bench SHALL cover: reset asserted mid-W burst -> all valids low the same cycle, IDLE; a new start completes cleanly.
- REQ-040 Bench SHALL cover: start pulsed while busy -> ignored, single done pulse.
